// File: rtl/mux_4_1_rr_pkg.sv
// Shared lane-count, select-width and lane index type for the 4-to-1
// round-robin stream multiplexer.
package mux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

endpackage : mux_pkg

// File: rtl/mux_4_1_rr_arb.sv
// Combinational 4-way round-robin arbiter: rotate requests so ptr sits at
// bit 0, pick the lowest set bit, then add ptr back to recover the lane.
module rr_arb_4
    import mux_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  lane_idx_t            ptr,
    output lane_idx_t            gnt_idx,
    output logic                 gnt_any
);

    logic [2*NUM_LANES-1:0] req_dbl_s;
    logic [NUM_LANES-1:0]   req_rot_s;
    lane_idx_t              off_s;

    assign req_dbl_s = {req, req};
    assign req_rot_s = req_dbl_s[{1'b0, ptr} +: NUM_LANES];

    // Priority-encode the rotated request vector (bit 0 = current ptr lane)
    always_comb begin
        off_s = 2'd0;
        if (req_rot_s[0]) begin
            off_s = 2'd0;
        end else if (req_rot_s[1]) begin
            off_s = 2'd1;
        end else if (req_rot_s[2]) begin
            off_s = 2'd2;
        end else if (req_rot_s[3]) begin
            off_s = 2'd3;
        end else begin
            off_s = 2'd0;
        end
    end

    // Un-rotate: the 2-bit add wraps naturally modulo 4
    assign gnt_idx = ptr + off_s;
    assign gnt_any = |req;

endmodule : rr_arb_4

// File: rtl/mux_4_1_rr.sv
// Registered 4-to-1 valid/ready stream merger. Each output word is tagged
// with its source lane so a downstream 1-to-4 demux can route it back.
module mux_4_1_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] y,
    output lane_idx_t        y_sel,
    output logic             y_valid,
    input  logic             y_ready
);

    logic [WIDTH-1:0]     y_q, y_d;
    lane_idx_t            sel_q, sel_d;
    logic                 valid_q, valid_d;
    lane_idx_t            ptr_q, ptr_d;

    logic [NUM_LANES-1:0] req_s;
    logic [NUM_LANES-1:0] rdy_s;
    lane_idx_t            gnt_idx_s;
    logic                 gnt_any_s;
    logic                 load_en_s;
    logic [WIDTH-1:0]     data_s;

    assign req_s     = {v3, v2, v1, v0};
    assign load_en_s = !valid_q | y_ready;

    rr_arb_4 u_arb (
        .req     (req_s),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Select the granted lane's data
    always_comb begin
        data_s = i0;
        case (gnt_idx_s)
            2'd0:    data_s = i0;
            2'd1:    data_s = i1;
            2'd2:    data_s = i2;
            2'd3:    data_s = i3;
            default: data_s = i0;
        endcase
    end

    // Ready is one-hot on the granted lane; suppressed while in reset so no
    // producer believes a word was taken on an edge that discards it.
    always_comb begin
        rdy_s = 4'b0000;
        if (load_en_s && gnt_any_s && !rst) begin
            rdy_s = 4'b0001 << gnt_idx_s;
        end else begin
            rdy_s = 4'b0000;
        end
    end

    assign {r3, r2, r1, r0} = rdy_s;

    // Next state of the output register stage and round-robin pointer
    always_comb begin
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en_s) begin
            if (gnt_any_s) begin
                y_d     = data_s;
                sel_d   = gnt_idx_s;
                valid_d = 1'b1;
                ptr_d   = gnt_idx_s + 2'd1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            ptr_q   <= 2'd0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_sel   = sel_q;
    assign y_valid = valid_q;

endmodule : mux_4_1_rr
